// File: rtl/mem_stage_nb.sv
// Non-blocking MEM stage: an in-order queue of in-flight instructions, in-order
// matching of data-SRAM responses to waiting loads, load extraction, and flush
// handling that absorbs the responses still owed to killed loads.
module mem_stage_nb #(
    parameter int DEPTH = 2,
    parameter int EXC_W = 7,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             es_to_ms_valid,
    output logic             ms_allowin,
    input  logic [31:0]      es_pc,
    input  logic             es_res_from_mem,
    input  logic             es_rf_we,
    input  logic [4:0]       es_rf_waddr,
    input  logic [31:0]      es_alu_result,
    input  logic [4:0]       es_ld_op,
    input  logic             es_req_issued,
    input  logic             es_csr_re,
    input  logic [EXC_W-1:0] es_except,
    input  logic             ws_allowin,
    output logic             ms_to_ws_valid,
    output logic [31:0]      ms_pc,
    output logic             ms_rf_we,
    output logic [4:0]       ms_rf_waddr,
    output logic [31:0]      ms_rf_wdata,
    output logic             ms_csr_re,
    output logic [EXC_W-1:0] ms_except,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    input  logic             except_flush,
    output logic             ms_ld_pending,
    output logic [CNT_W-1:0] ms_occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + 1;

    // Entry payload
    logic [31:0]      pc_reg    [DEPTH];
    logic [31:0]      alu_reg   [DEPTH];
    logic [31:0]      data_reg  [DEPTH];
    logic [4:0]       waddr_reg [DEPTH];
    logic [4:0]       ldop_reg  [DEPTH];
    logic [EXC_W-1:0] exc_reg   [DEPTH];
    logic [DEPTH-1:0] rfm_reg, rfwe_reg, csr_reg;
    // Entry status
    logic [DEPTH-1:0] valid_reg, wait_reg, got_reg;

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] discard_reg, discard_next;

    logic [DEPTH-1:0] pend, pend_keep, ldq;
    logic             route_found, route_en, head_hit, head_ready;
    logic [PTR_W-1:0] route_idx, scan_idx;
    logic [CNT_W-1:0] pend_cnt;
    logic             push, pop, disc_dec;
    logic [SUM_W-1:0] disc_sum;
    logic [31:0]      ld_src, ld_val;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [1:0]       addr_lo;
    logic [4:0]       head_op;

    // Per-entry status decode: waiting for data, and holding a load
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign pend[gi]      = valid_reg[gi] & wait_reg[gi] & ~got_reg[gi];
            assign ldq[gi]       = valid_reg[gi] & rfm_reg[gi];
            assign pend_keep[gi] = pend[gi] & ~(route_en && (route_idx == PTR_W'(gi)));
        end
    endgenerate

    // Find the oldest entry still owed a response (scan from youngest so oldest wins)
    always_comb begin
        route_found = 1'b0;
        route_idx   = '0;
        scan_idx    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            scan_idx = head_reg + PTR_W'(k);
            if (pend[scan_idx]) begin
                route_found = 1'b1;
                route_idx   = scan_idx;
            end
        end
    end

    assign route_en   = data_sram_data_ok && (discard_reg == '0) && route_found;
    assign head_hit   = route_en && (route_idx == head_reg);
    assign head_ready = valid_reg[head_reg] &
                        (~wait_reg[head_reg] | got_reg[head_reg] | head_hit);

    assign ms_allowin = (count_reg < CNT_W'(DEPTH)) & ~except_flush;
    assign push       = es_to_ms_valid & ms_allowin;
    assign pop        = head_ready & ws_allowin;

    // Occupancy and discard bookkeeping; a flush adds every still-owed response
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt = pend_cnt + CNT_W'(pend_keep[i]);
        end
        disc_dec = data_sram_data_ok && (discard_reg != '0);
        disc_sum = {1'b0, discard_reg} - SUM_W'(disc_dec)
                 + (except_flush ? {1'b0, pend_cnt} : SUM_W'(0));
        discard_next = (disc_sum > SUM_W'(DEPTH)) ? CNT_W'(DEPTH) : disc_sum[CNT_W-1:0];
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Load extraction from the bypassed response or the head's buffered data
    always_comb begin
        ld_src   = head_hit ? data_sram_rdata : data_reg[head_reg];
        addr_lo  = alu_reg[head_reg][1:0];
        head_op  = ldop_reg[head_reg];
        half_sel = addr_lo[1] ? ld_src[31:16] : ld_src[15:0];
        byte_sel = ld_src[{addr_lo, 3'b000} +: 8];
        ld_val   = '0;
        if (head_op[4]) begin
            ld_val = ld_src;
        end else if (head_op[3]) begin
            ld_val = {{16{half_sel[15]}}, half_sel};
        end else if (head_op[2]) begin
            ld_val = {16'h0000, half_sel};
        end else if (head_op[1]) begin
            ld_val = {{24{byte_sel[7]}}, byte_sel};
        end else if (head_op[0]) begin
            ld_val = {24'h000000, byte_sel};
        end
    end

    assign ms_to_ws_valid = head_ready;
    assign ms_pc          = pc_reg[head_reg];
    assign ms_rf_we       = head_ready & rfwe_reg[head_reg];
    assign ms_rf_waddr    = waddr_reg[head_reg];
    assign ms_rf_wdata    = rfm_reg[head_reg] ? ld_val : alu_reg[head_reg];
    assign ms_csr_re      = csr_reg[head_reg];
    assign ms_except      = valid_reg[head_reg] ? exc_reg[head_reg] : '0;
    assign ms_ld_pending  = |ldq;
    assign ms_occupancy   = count_reg;

    // Queue state: flush beats push; response capture, pop and push otherwise
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            discard_reg <= '0;
            valid_reg   <= '0;
            wait_reg    <= '0;
            got_reg     <= '0;
            rfm_reg     <= '0;
            rfwe_reg    <= '0;
            csr_reg     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_reg[i]    <= '0;
                alu_reg[i]   <= '0;
                data_reg[i]  <= '0;
                waddr_reg[i] <= '0;
                ldop_reg[i]  <= '0;
                exc_reg[i]   <= '0;
            end
        end else if (except_flush) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            valid_reg   <= '0;
            discard_reg <= discard_next;
        end else begin
            discard_reg <= discard_next;
            count_reg   <= count_next;
            if (route_en) begin
                got_reg[route_idx]  <= 1'b1;
                data_reg[route_idx] <= data_sram_rdata;
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            if (push) begin
                valid_reg[tail_reg] <= 1'b1;
                wait_reg[tail_reg]  <= es_req_issued;
                got_reg[tail_reg]   <= 1'b0;
                rfm_reg[tail_reg]   <= es_res_from_mem;
                rfwe_reg[tail_reg]  <= es_rf_we;
                csr_reg[tail_reg]   <= es_csr_re;
                pc_reg[tail_reg]    <= es_pc;
                alu_reg[tail_reg]   <= es_alu_result;
                data_reg[tail_reg]  <= '0;
                waddr_reg[tail_reg] <= es_rf_waddr;
                ldop_reg[tail_reg]  <= es_ld_op;
                exc_reg[tail_reg]   <= es_except;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
        end
    end

    // Every response must either be owed to a killed load or have a waiting entry
    always_ff @(posedge clk) begin
        if (resetn && data_sram_data_ok) begin
            assert (discard_reg != '0 || route_found);
        end
    end
endmodule
